// File: rtl/led_status_pkg.sv
// Shared constants for the LED status controller: mode encodings and PWM width.
// Optional feature macro used by the top: LED_DIM_EN (PWM dimming of O_led).
package led_status_pkg;

  localparam logic [1:0] MODE_STATUS   = 2'd0;
  localparam logic [1:0] MODE_ACTIVITY = 2'd1;
  localparam logic [1:0] MODE_OFF      = 2'd2;
  localparam logic [1:0] MODE_TEST     = 2'd3;

  localparam int PWM_BITS = 8;

endpackage

// File: rtl/hb_monitor.sv
// One heartbeat channel: 3-flop synchroniser, toggle detect and a saturating
// activity timeout counter that is reloaded (not accumulated) on every toggle.
module hb_monitor
  import led_status_pkg::*;
#(
  parameter int pTIMEOUT_BITS = 16
) (
  input  logic fe_clk,
  input  logic reset,
  input  logic I_heartbeat,
  output logic O_s3,
  output logic O_alive
);

  localparam logic [pTIMEOUT_BITS-1:0] CNT_ONE = {{(pTIMEOUT_BITS-1){1'b0}}, 1'b1};

  logic                     s1_d, s1_q;
  logic                     s2_d, s2_q;
  logic                     s3_d, s3_q;
  logic                     edge_s;
  logic [pTIMEOUT_BITS-1:0] cnt_d, cnt_q;

  // Next-state logic for the synchroniser chain and timeout counter
  always_comb begin
    s1_d   = I_heartbeat;
    s2_d   = s1_q;
    s3_d   = s2_q;
    edge_s = s2_q ^ s3_q;
    if (edge_s) begin
      cnt_d = {pTIMEOUT_BITS{1'b1}};
    end else if (cnt_q != {pTIMEOUT_BITS{1'b0}}) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers
  always_ff @(posedge fe_clk) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      cnt_q <= {pTIMEOUT_BITS{1'b0}};
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      cnt_q <= cnt_d;
    end
  end

  assign O_s3    = s3_q;
  assign O_alive = (cnt_q != {pTIMEOUT_BITS{1'b0}});

endmodule

// File: rtl/led_status_ctrl.sv
// N-channel clock-activity monitor and M-LED front-panel driver with error flash.
// Define LED_DIM_EN to build the PWM dimmer driven by I_brightness.
module led_status_ctrl
  import led_status_pkg::*;
#(
  parameter int pCHANNELS     = 2,
  parameter int pLEDS         = 4,
  parameter int pTIMEOUT_BITS = 16,
  parameter int pFLASH_BITS   = 22
) (
  input  logic                 fe_clk,
  input  logic                 reset,
  input  logic [pCHANNELS-1:0] I_heartbeat,
  input  logic [pLEDS-1:0]     I_status,
  input  logic [1:0]           I_mode,
  input  logic                 I_error,
  input  logic                 I_clear_error,
  input  logic [7:0]           I_brightness,
  output logic [pCHANNELS-1:0] O_alive,
  output logic                 O_error_latched,
  output logic                 O_flash,
  output logic [pLEDS-1:0]     O_led
);

  localparam logic [pFLASH_BITS-1:0] FLASH_ONE = {{(pFLASH_BITS-1){1'b0}}, 1'b1};

  logic [pCHANNELS-1:0]   s3_s;
  logic [pCHANNELS-1:0]   alive_s;
  logic [pLEDS-1:0]       act_s;
  logic [pLEDS-1:0]       mode_led_s;
  logic [pLEDS-1:0]       led_next_s;
  logic [pLEDS-1:0]       led_d, led_q;
  logic [pFLASH_BITS-1:0] flash_d, flash_q;
  logic                   err_d, err_q;

  for (genvar c = 0; c < pCHANNELS; c++) begin : g_hb
    hb_monitor #(
      .pTIMEOUT_BITS(pTIMEOUT_BITS)
    ) u_hb_monitor (
      .fe_clk      (fe_clk),
      .reset       (reset),
      .I_heartbeat (I_heartbeat[c]),
      .O_s3        (s3_s[c]),
      .O_alive     (alive_s[c])
    );
  end

  // LEDs beyond the channel count wrap around onto the channels again
  for (genvar i = 0; i < pLEDS; i++) begin : g_act
    localparam int CH = i % pCHANNELS;
    assign act_s[i] = s3_s[CH] & alive_s[CH];
  end

  // Flash counter, error latch (set dominates clear) and LED selection
  always_comb begin
    flash_d = flash_q + FLASH_ONE;
    if (I_error) begin
      err_d = 1'b1;
    end else if (I_clear_error) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    case (I_mode)
      MODE_STATUS:   mode_led_s = I_status;
      MODE_ACTIVITY: mode_led_s = act_s;
      MODE_OFF:      mode_led_s = {pLEDS{1'b0}};
      MODE_TEST:     mode_led_s = {pLEDS{1'b1}};
      default:       mode_led_s = {pLEDS{1'b0}};
    endcase
    if (err_q) begin
      led_next_s = {pLEDS{flash_q[pFLASH_BITS-1]}};
    end else begin
      led_next_s = mode_led_s;
    end
  end

`ifdef LED_DIM_EN
  logic [PWM_BITS-1:0] pwm_d, pwm_q;
  logic                pwm_on_s;

  // PWM counter and duty mask; the error flash is dimmed as well
  always_comb begin
    pwm_d    = pwm_q + {{(PWM_BITS-1){1'b0}}, 1'b1};
    pwm_on_s = (pwm_q < I_brightness);
    led_d    = led_next_s & {pLEDS{pwm_on_s}};
  end

  // PWM counter register
  always_ff @(posedge fe_clk) begin
    if (reset) begin
      pwm_q <= {PWM_BITS{1'b0}};
    end else begin
      pwm_q <= pwm_d;
    end
  end
`else
  logic unused_brightness_s;
  assign unused_brightness_s = ^I_brightness;
  assign led_d = led_next_s;
`endif

  // Top-level state registers
  always_ff @(posedge fe_clk) begin
    if (reset) begin
      flash_q <= {pFLASH_BITS{1'b0}};
      err_q   <= 1'b0;
      led_q   <= {pLEDS{1'b0}};
    end else begin
      flash_q <= flash_d;
      err_q   <= err_d;
      led_q   <= led_d;
    end
  end

  assign O_alive         = alive_s;
  assign O_error_latched = err_q;
  assign O_flash         = flash_q[pFLASH_BITS-1];
  assign O_led           = led_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl: stimulus queues expected values tagged with
// the cycle they must appear on; a monitor pops and compares them on negedges.
module tb_led_status_ctrl;

  localparam int pCHANNELS     = 2;
  localparam int pLEDS         = 4;
  localparam int pTIMEOUT_BITS = 4;
  localparam int pFLASH_BITS   = 4;

  localparam int K_ALIVE = 0;
  localparam int K_LED   = 1;
  localparam int K_ERR   = 2;
  localparam int K_FLASH = 3;

  logic       fe_clk        = 1'b0;
  logic       reset         = 1'b1;
  logic [1:0] I_heartbeat   = 2'b00;
  logic [3:0] I_status      = 4'b0000;
  logic [1:0] I_mode        = 2'd0;
  logic       I_error       = 1'b0;
  logic       I_clear_error = 1'b0;
  logic [7:0] I_brightness  = 8'd0;
  logic [1:0] O_alive;
  logic       O_error_latched;
  logic       O_flash;
  logic [3:0] O_led;

  int cyc    = 0;
  int r_edge = 0;
  int bright = 0;
  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    int         cyc;
    int         kind;
    logic [3:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];

  led_status_ctrl #(
    .pCHANNELS     (pCHANNELS),
    .pLEDS         (pLEDS),
    .pTIMEOUT_BITS (pTIMEOUT_BITS),
    .pFLASH_BITS   (pFLASH_BITS)
  ) dut (
    .fe_clk          (fe_clk),
    .reset           (reset),
    .I_heartbeat     (I_heartbeat),
    .I_status        (I_status),
    .I_mode          (I_mode),
    .I_error         (I_error),
    .I_clear_error   (I_clear_error),
    .I_brightness    (I_brightness),
    .O_alive         (O_alive),
    .O_error_latched (O_error_latched),
    .O_flash         (O_flash),
    .O_led           (O_led)
  );

  always #5 fe_clk = ~fe_clk;

  always @(posedge fe_clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required end", cyc);
    $fatal(1);
  end

  function automatic logic [3:0] sample(int kind);
    case (kind)
      K_ALIVE: return {2'b00, O_alive};
      K_LED:   return O_led;
      K_ERR:   return {3'b000, O_error_latched};
      default: return {3'b000, O_flash};
    endcase
  endfunction

  // flash counter value after edge c is (c - r_edge) mod 16; its MSB is O_flash
  function automatic logic [3:0] flash_at(int c);
    return ((((c - r_edge) % 16) >= 8) ? 4'b0001 : 4'b0000);
  endfunction

  function automatic logic [3:0] led_exp(int c, logic [3:0] raw);
`ifdef LED_DIM_EN
    return ((((c - 1 - r_edge) % 256) < bright) ? raw : 4'b0000);
`else
    return raw;
`endif
  endfunction

  task automatic push(int c, int kind, logic [3:0] e, string name);
    exp_t x;
    x.cyc = c; x.kind = kind; x.exp = e; x.name = name;
    sb.push_back(x);
  endtask

  task automatic wait_until(int c);
    while (cyc < c) @(negedge fe_clk);
  endtask

  task automatic check(string name, logic [8:0] act, logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: got %0d required %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare every queued expectation on the cycle it is due
  always @(negedge fe_clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t x;
      logic [3:0] act;
      x = sb.pop_front();
      act = sample(x.kind);
      n_vec++;
      if (x.cyc < cyc) begin
        n_miss++;
        $display("FAIL %s late: due cycle %0d, now %0d", x.name, x.cyc, cyc);
      end else if (act !== x.exp) begin
        n_miss++;
        $display("FAIL %s @cycle %0d: got %b required %b", x.name, cyc, act, x.exp);
      end
    end
  end

  initial begin
    int t, e, b, cl, m, x;
    int cnt[4];
`ifdef LED_DIM_EN
    bright = 255;
`else
    bright = 0;
`endif
    I_brightness = 8'(bright);

    // reset then idle
    wait_until(3);
    reset  = 1'b0;
    r_edge = 3;
    push(23, K_ALIVE, 4'b0000, "idle_alive");
    push(23, K_LED,   led_exp(23, 4'b0000), "idle_led");
    push(23, K_ERR,   4'b0000, "idle_err");
    push(23, K_FLASH, flash_at(23), "idle_flash_lo");
    push(28, K_FLASH, flash_at(28), "idle_flash_hi");
    wait_until(30);

    // single toggle, then a reload while the counter is at 5
    t = cyc;
    I_heartbeat[0] = 1'b1;
    push(t + 2,  K_ALIVE, 4'b0000, "alive_not_yet");
    push(t + 3,  K_ALIVE, 4'b0001, "alive_rise");
    push(t + 17, K_ALIVE, 4'b0001, "alive_hold");
    push(t + 18, K_ALIVE, 4'b0000, "alive_timeout");
    wait_until(t + 20);
    t = cyc;
    I_heartbeat[0] = 1'b0;
    push(t + 2,  K_ALIVE, 4'b0000, "alive2_not_yet");
    push(t + 3,  K_ALIVE, 4'b0001, "alive2_rise");
    push(t + 20, K_ALIVE, 4'b0001, "reload_extends");
    push(t + 27, K_ALIVE, 4'b0001, "reload_hold");
    push(t + 28, K_ALIVE, 4'b0000, "reload_timeout");
    wait_until(t + 10);
    I_heartbeat[0] = 1'b1;
    wait_until(t + 30);

    // activity mode, heartbeat toggling every 4 cycles then stopping
    t = cyc;
    I_mode = 2'd1;
    push(t + 2,  K_LED, led_exp(t + 2,  4'b0000), "act_dead");
    push(t + 11, K_LED, led_exp(t + 11, 4'b0000), "act_low");
    push(t + 12, K_LED, led_exp(t + 12, 4'b0101), "act_rise");
    push(t + 15, K_LED, led_exp(t + 15, 4'b0101), "act_high");
    push(t + 16, K_LED, led_exp(t + 16, 4'b0000), "act_fall");
    push(t + 20, K_LED, led_exp(t + 20, 4'b0101), "act_rise2");
    push(t + 24, K_LED, led_exp(t + 24, 4'b0000), "act_fall2");
    push(t + 28, K_LED, led_exp(t + 28, 4'b0101), "act_rise3");
    push(t + 42, K_LED, led_exp(t + 42, 4'b0101), "act_last_lit");
    push(t + 43, K_LED, led_exp(t + 43, 4'b0000), "act_dark");
    for (int j = 1; j <= 6; j++) begin
      wait_until(t + 4 * j);
      I_heartbeat[0] = ~I_heartbeat[0];
    end
    wait_until(t + 45);

    // error handling in lamp-test mode
    t  = cyc;
    e  = t + 3;
    b  = e + 20;
    cl = b + 5;
    I_mode = 2'd3;
    push(t + 1, K_LED, led_exp(t + 1, 4'b1111), "test_on");
    push(e,     K_ERR, 4'b0000, "err_before");
    push(e + 1, K_ERR, 4'b0001, "err_set");
    push(e + 1, K_LED, led_exp(e + 1, 4'b1111), "err_led_delay");
    for (int c = e + 2; c <= e + 17; c++) begin
      push(c, K_LED,   led_exp(c, {4{flash_at(c - 1) == 4'b0001}}), "err_flash_led");
      push(c, K_FLASH, flash_at(c), "flash_period");
    end
    push(b + 1,  K_ERR, 4'b0001, "set_wins");
    push(b + 2,  K_ERR, 4'b0001, "set_wins_hold");
    push(cl,     K_ERR, 4'b0001, "clear_delay");
    push(cl + 1, K_ERR, 4'b0000, "cleared");
    push(cl + 1, K_LED, led_exp(cl + 1, {4{flash_at(cl) == 4'b0001}}), "clear_led_flash");
    push(cl + 2, K_LED, led_exp(cl + 2, 4'b1111), "clear_led_on");
    wait_until(e);
    I_error = 1'b1;
    wait_until(e + 1);
    I_error = 1'b0;
    wait_until(b);
    I_error = 1'b1;
    I_clear_error = 1'b1;
    wait_until(b + 1);
    I_error = 1'b0;
    I_clear_error = 1'b0;
    wait_until(cl);
    I_clear_error = 1'b1;
    wait_until(cl + 1);
    I_clear_error = 1'b0;
    wait_until(cl + 3);

    // mode changes with a fixed status pattern
    m = cyc;
    I_status = 4'b1010;
    I_mode   = 2'd0;
    push(m,     K_LED, led_exp(m,     4'b1111), "mode_prev");
    push(m + 1, K_LED, led_exp(m + 1, 4'b1010), "mode_status");
    push(m + 4, K_LED, led_exp(m + 4, 4'b0000), "mode_off");
    push(m + 7, K_LED, led_exp(m + 7, 4'b1111), "mode_test");
    wait_until(m + 3);
    I_mode = 2'd2;
    wait_until(m + 6);
    I_mode = 2'd3;
    wait_until(m + 8);

    // reset mid-operation with a latched error and a live channel
    x = cyc;
    I_heartbeat[1] = 1'b1;
    I_error = 1'b1;
    push(x + 3, K_ALIVE, 4'b0010, "ch1_alive");
    push(x + 5, K_ERR,   4'b0001, "pre_reset_err");
    push(x + 6, K_LED,   4'b0000, "reset_led");
    push(x + 6, K_ERR,   4'b0000, "reset_err");
    push(x + 6, K_ALIVE, 4'b0000, "reset_alive");
    push(x + 6, K_FLASH, 4'b0000, "reset_flash");
    wait_until(x + 1);
    I_error = 1'b0;
    wait_until(x + 5);
    reset = 1'b1;
    wait_until(x + 6);
    reset  = 1'b0;
    r_edge = x + 6;
    push(x + 7, K_LED, led_exp(x + 7, 4'b1111), "post_reset_led");
    push(x + 7, K_ERR, 4'b0000, "post_reset_err");
    wait_until(x + 12);

`ifdef LED_DIM_EN
    // duty-cycle counts over a full PWM period
    I_brightness = 8'd64;
    bright = 64;
    wait_until(cyc + 2);
    for (int l = 0; l < 4; l++) cnt[l] = 0;
    repeat (256) begin
      @(negedge fe_clk);
      for (int l = 0; l < 4; l++) cnt[l] += int'(O_led[l]);
    end
    for (int l = 0; l < 4; l++) check("dim64_count", 9'(cnt[l]), 9'd64);
    I_brightness = 8'd0;
    bright = 0;
    wait_until(cyc + 2);
    for (int l = 0; l < 4; l++) cnt[l] = 0;
    repeat (256) begin
      @(negedge fe_clk);
      for (int l = 0; l < 4; l++) cnt[l] += int'(O_led[l]);
    end
    for (int l = 0; l < 4; l++) check("dim0_count", 9'(cnt[l]), 9'd0);
`else
    for (int l = 0; l < 4; l++) cnt[l] = 0;
`endif

    wait_until(cyc + 3);
    while (sb.size() > 0) begin
      exp_t y;
      y = sb.pop_front();
      n_vec++;
      n_miss++;
      $display("FAIL %s never checked: due cycle %0d, now %0d", y.name, y.cyc, cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
